// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module   : mdu_ctrl
// Function : Multiply/divide sequencer. It drives an external pipelined
//            multiplier and runs an internal 32-step restoring divider.
//            Define MDU_EARLY_TERM_EN to let |opA| < |opB| divides finish in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        flush,
    input  logic        is_busbusy,
    output logic        mul_start,
    output logic        mul_sign,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_prod,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    localparam int C_CNT_MAX = (MUL_LAT > 32) ? MUL_LAT : 32;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_rem;
    logic [31:0]          r_quo;
    logic [31:0]          r_dsr;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_early;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_hi_fin;
    logic [31:0] w_lo_fin;

    // Magnitudes only differ from the raw operands for the signed divide.
    assign w_abs_a = (op[0] && opA[31]) ? (~opA + 32'd1) : opA;
    assign w_abs_b = (op[0] && opB[31]) ? (~opB + 32'd1) : opB;

`ifdef MDU_EARLY_TERM_EN
    assign w_early = (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step; a set shifted MSB means the partial remainder already exceeds D.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {1'b0, r_dsr};
    assign w_ge     = w_shift[32] | ~w_diff[32];
    assign w_rem_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};
    assign w_hi_fin = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;
    assign w_lo_fin = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;

    assign busy = ((r_state == S_IDLE) && start_valid && !flush) ||
                  (r_state == S_MUL) || (r_state == S_DIV) ||
                  ((r_state == S_DONE) && is_busbusy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dsr     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            mul_start <= 1'b0;
            mul_sign  <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start_valid && !flush) begin
                        mul_a    <= opA;
                        mul_b    <= opB;
                        mul_sign <= op[0] & ~op[1];
                        if (!op[1]) begin
                            r_state   <= S_MUL;
                            r_cnt     <= C_CNT_W'(MUL_LAT);
                            mul_start <= 1'b1;
                        end else if (opB == 32'd0) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            result_hi <= opA;
                            result_lo <= 32'hFFFF_FFFF;
                        end else if (w_early) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            result_hi <= opA;
                            result_lo <= 32'd0;
                        end else begin
                            r_state <= S_DIV;
                            r_cnt   <= C_CNT_W'(32);
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_dsr   <= w_abs_b;
                            r_neg_q <= op[0] & (opA[31] ^ opB[31]);
                            r_neg_r <= op[0] & opA[31];
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == C_CNT_W'(1)) begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        result_hi <= mul_prod[63:32];
                        result_lo <= mul_prod[31:0];
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == C_CNT_W'(1)) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            result_hi <= w_hi_fin;
                            result_lo <= w_lo_fin;
                        end else begin
                            r_cnt <= r_cnt - C_CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (flush || !is_busbusy) begin
                        r_state <= S_IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module   : tb_mdu_ctrl
// Function : Randomized self-checking bench for mdu_ctrl against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        flush = 1'b0;
    logic        is_busbusy = 1'b0;
    logic        mul_start;
    logic        mul_sign;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_prod = 64'hDEAD_BEEF_0BAD_F00D;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_valid(start_valid),
        .op         (op),
        .opA        (opA),
        .opB        (opB),
        .flush      (flush),
        .is_busbusy (is_busbusy),
        .mul_start  (mul_start),
        .mul_sign   (mul_sign),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_prod   (mul_prod),
        .busy       (busy),
        .done       (done),
        .result_hi  (result_hi),
        .result_lo  (result_lo)
    );

    always #5 clk = ~clk;

    // External multiplier: captures the product on the start pulse and holds it.
    always @(posedge clk) begin
        if (mul_start) begin
            if (mul_sign)
                mul_prod <= 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
            else
                mul_prod <= {32'd0, mul_a} * {32'd0, mul_b};
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int lat);
        logic [63:0] p;
        longint sa, sb, q, r, ma, mb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = 33;
        case (o)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                hi = p[63:32]; lo = p[31:0]; lat = MUL_LAT + 1;
            end
            2'b01: begin
                p = 64'(sa * sb);
                hi = p[63:32]; lo = p[31:0]; lat = MUL_LAT + 1;
            end
            2'b10: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    lo = a / b; hi = a % b;
`ifdef MDU_EARLY_TERM_EN
                    if (a < b) lat = 1;
`endif
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = 32'(q); hi = 32'(r);
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
`ifdef MDU_EARLY_TERM_EN
                    if (ma < mb) lat = 1;
`else
                    if (ma < 0 || mb < 0) lat = 33;
`endif
                end
            end
        endcase
    endfunction

    // Called just after a falling edge with the block idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int flush_at);
        logic [31:0] ehi, elo;
        int lat, i;
        bit flushed;
        model(o, a, b, ehi, elo, lat);
        start_valid = 1'b1; op = o; opA = a; opB = b; flush = 1'b0; is_busbusy = 1'b0;
        #1 check("busy_req", {63'd0, busy}, 64'd1);
        @(posedge clk); @(negedge clk);
        i = 1; flushed = 0;
        start_valid = 1'($urandom_range(0, 1)); op = 2'($urandom); opA = $urandom; opB = $urandom;
        while (!done && i < 100 && !flushed) begin
            check("mul_start", {63'd0, mul_start}, {63'd0, (i == 1 && !o[1])});
            if (i == 1 && !o[1]) begin
                check("mul_a", {32'd0, mul_a}, {32'd0, a});
                check("mul_b", {32'd0, mul_b}, {32'd0, b});
            end
            check("busy_run", {63'd0, busy}, 64'd1);
            if (flush_at == i) begin
                flush = 1'b1; start_valid = 1'b0;
                @(posedge clk); @(negedge clk);
                flush = 1'b0;
                #1;
                check("flush_busy", {63'd0, busy}, 64'd0);
                check("flush_done", {63'd0, done}, 64'd0);
                check("flush_res", {result_hi, result_lo}, {prev_hi, prev_lo});
                flushed = 1;
            end else begin
                @(posedge clk); @(negedge clk);
                i++;
            end
        end
        if (!flushed) begin
            check("latency", 64'(i), 64'(lat));
            check("result_hi", {32'd0, result_hi}, {32'd0, ehi});
            check("result_lo", {32'd0, result_lo}, {32'd0, elo});
            for (int h = 0; h < hold; h++) begin
                is_busbusy = 1'b1;
                start_valid = 1'($urandom_range(0, 1)); opA = $urandom; opB = $urandom;
                #1 check("hold_busy", {63'd0, busy}, 64'd1);
                @(posedge clk); @(negedge clk);
                check("hold_done", {63'd0, done}, 64'd1);
                check("hold_res", {result_hi, result_lo}, {ehi, elo});
            end
            is_busbusy = 1'b0; start_valid = 1'b0;
            #1 check("exit_busy", {63'd0, busy}, 64'd0);
            @(posedge clk); @(negedge clk);
            check("idle_done", {63'd0, done}, 64'd0);
            check("idle_busy", {63'd0, busy}, 64'd0);
            prev_hi = ehi; prev_lo = elo;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int mode;
        @(negedge clk); @(negedge clk);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_res", {result_hi, result_lo}, 64'd0);
        check("rst_mul", {31'd0, mul_start, mul_a}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(2'b10, 32'd100, 32'd7, 0, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op(2'b10, 32'd9, 32'd3, 5, 0);
        run_op(2'b11, 32'd50, 32'd5, 0, 10);
        run_op(2'b10, 32'd8, 32'd0, 0, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op(2'b01, 32'd1234, 32'd5678, 0, 1);
        run_op(2'b10, 32'd3, 32'd10, 0, 0);
        run_op(2'b11, 32'hFFFF_FFFD, 32'd10, 0, 0);

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 4);
            if (mode == 1) b = $urandom_range(1, 15);
            if (mode == 2) b = 32'd0;
            if (mode == 3) a = $urandom_range(0, 20);
            if (mode == 4) begin
                a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            end
            run_op(2'($urandom), a, b, $urandom_range(0, 3), 0);
        end

        // Asynchronous reset in the middle of a signed divide.
        start_valid = 1'b1; op = 2'b11; opA = 32'd50; opB = 32'd5;
        @(posedge clk); @(negedge clk);
        start_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #1 reset = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_res", {result_hi, result_lo}, 64'd0);
        check("arst_mul", {mul_a, mul_b}, 64'd0);
        check("arst_ctl", {62'd0, mul_start, mul_sign}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        prev_hi = '0; prev_lo = '0;
        @(negedge clk);
        run_op(2'b10, 32'd77, 32'd4, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer serving the execute stage. Accepts one MULT/MULTU/DIV/DIVU request at a time and drives the external pipelined multiplier. Runs an internal 32-step restoring radix-2 divider with sign correction. Holds the execute stage via `busy` and presents registered HI/LO results until the bus-busy hold releases.

Parameters:
- MUL_LAT, 2, pipeline depth of the external multiplier in cycles (≥1); product sampled MUL_LAT cycles after mul_start.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start_valid  in  1  request from execute stage
- op  in  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
- opA  in  32  rs operand (dividend / multiplicand)
- opB  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception/branch kill of current op
- is_busbusy  in  1  downstream stall; results must be held
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_sign  out  1  signed multiply select
- mul_a  out  32  latched opA to multiplier
- mul_b  out  32  latched opB to multiplier
- mul_prod  in  64  multiplier product
- busy  out  1  stall execute stage (opreat_over = ~busy)
- done  out  1  result_hi/result_lo valid
- result_hi  out  32  HI value (product[63:32] / remainder)
- result_lo  out  32  LO value (product[31:0] / quotient)

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (reset=0, async) forces IDLE. Reset also clears all registered outputs, mul_a/mul_b, counter and divider registers to 0. Reset mid-operation aborts with no done.
- IDLE: start_valid=1 and flush=0 sampled at cycle N latches operands and op.
  - op[1]=0: mul_start=1 in cycle N+1; state goes to MUL with count=MUL_LAT.
  - op[1]=1, opB≠0: state goes to DIV with count=32. The divider loads R=0 and Q=|opA|, with D=|opB| for DIV or raw values for DIVU.
  - op[1]=1, opB=0: state goes to DONE at N+1 with hi=opA, lo=32'hFFFF_FFFF.
- MUL: count decrements each cycle. When count reaches 1, mul_prod is registered into result_hi/lo and state goes to DONE. done first high at N+MUL_LAT+1.
- DIV: each cycle computes {R,Q} = {R,Q}<<1, then T = R − D over 33 bits. If T ≥ 0: R = T and Q[0] = 1.
  - After 32 steps, sign correction is applied during the registering cycle. For DIV: lo = −Q if opA[31]^opB[31], else Q; hi = −R if opA[31], else R. DIVU has no correction.
  - done first high at N+33.
- DONE: done=1 and results are stable.
  - If is_busbusy=0, the result is consumed this cycle and the state returns to IDLE.
  - If is_busbusy=1, the block stays in DONE holding all outputs.
- busy is combinational: (IDLE & start_valid & ~flush) | MUL | DIV | (DONE & is_busbusy). done=0 in every state other than DONE.
- start_valid is ignored outside IDLE. A new request is accepted only from IDLE, i.e. the cycle after the DONE exit.
- flush=1 in MUL, DIV or DONE returns the block to IDLE next cycle. It suppresses done, keeps the results unchanged and de-asserts busy. flush has priority over completion in the same cycle.
- mul_sign = latched op[0] & ~op[1].
- Arithmetic: 33-bit subtract for the divider. −0x8000_0000 / −1 gives lo=0x8000_0000, hi=0 (wrap, no trap).

Optional Feature:
- MDU_EARLY_TERM_EN
  - Defined: in IDLE, a divide with opB≠0 and |opA|<|opB| (unsigned compare on magnitudes) skips DIV. It goes to DONE at N+1 with lo=0 and hi=opA (original signed value).
  - Undefined: all nonzero-divisor divides take the full 32 steps (done at N+33).

Test Plan:
- DIVU opA=100, opB=7 at cycle N -> done at N+33, lo=14, hi=2; busy high N..N+32.
- DIV opA=0xFFFF_FFF9 (−7), opB=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- MULT vs MULTU with opA=0xFFFF_FFFF, opB=2, MUL_LAT=2:
  - MULT -> mul_start at N+1, done at N+3, hi=0xFFFF_FFFF, lo=0xFFFF_FFFE.
  - MULTU -> hi=0x0000_0001, lo=0xFFFF_FFFE.
- DIVU 9/3 with is_busbusy=1 for 5 cycles at completion -> done and results (lo=3, hi=0) held unchanged 5 cycles; IDLE the cycle after is_busbusy drops; start_valid during the hold is ignored.
- DIV 50/5 with flush at N+10 -> IDLE at N+11, done never asserts, busy=0 from N+11. A new DIVU 8/0 accepted at N+11 -> done at N+12, hi=8, lo=0xFFFF_FFFF.
- reset pulled low at N+5 of a DIV -> all outputs 0 asynchronously. With MDU_EARLY_TERM_EN, DIVU 3/10 -> done at N+1, lo=0, hi=3.
